// File: rtl/rr_encoder_arbiter.sv
// rr_encoder_arbiter
//   Round-robin arbiter for 8 requesters. The winner is reported as a
//   registered one-hot grant and as its registered binary index. The
//   enable input gates arbitration. Each ownership is capped at MAX_HOLD
//   consecutive cycles.
//
//   State table:
//     IDLE  | no owner; arbitrate requests from ptr upward (circular)
//     GRANT | grant_idx owns the resource; watch enable, own req, hold_cnt
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous reset, active-high
//   enable       in   arbitration enable; low aborts any current grant
//   req[N]       in   request vector
//   grant[N]     out  one-hot grant (registered)
//   grant_idx    out  binary index of grant, 0 when no grant (registered)
//   grant_valid  out  OR of grant bits
//   timeout      out  one-cycle pulse after a MAX_HOLD forced release
module rr_encoder_arbiter #(
  parameter int N        = 8,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [7:0]       hold_q, hold_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             timeout_q, timeout_d;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand;

  // Circular first-set search starting at ptr.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < N; k++) begin
      cand = ptr_q + IDX_W'(k);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable && pick_found) begin
          state_d           = S_GRANT;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          idx_d             = pick_idx;
          hold_d            = 8'd1;
        end
      end
      default: begin
        if (!enable || !req[idx_q] || (hold_q == 8'(MAX_HOLD))) begin
          // Abort, voluntary release and forced release all rotate the
          // pointer past the owner; only the forced case flags timeout.
          state_d   = S_IDLE;
          grant_d   = '0;
          idx_d     = '0;
          hold_d    = '0;
          ptr_d     = idx_q + IDX_W'(1);
          timeout_d = enable && req[idx_q];
        end else if (hold_q != 8'd255) begin
          hold_d = hold_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      grant_q   <= '0;
      idx_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = |grant_q;
  assign timeout     = timeout_q;

endmodule
